pwm_duty_decoder: RTL and testbench

- Receive side of the audio PWM link: recovers the duty value from a PWM waveform with a fixed period of 2^DUTY_WIDTH clocks, emitting one duty sample per period.
- Drop-in inverse of the team's counter-compare PWM generator, where the output is high for `duty` cycles and then low for the rest of each period.
- Used for loopback self-test of the audio path and for measuring externally supplied PWM.
- Flags period or framing violations instead of reporting bad values.

---
 rtl/pwm_duty_decoder.sv | 148 ++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// Recovers the duty value from a fixed-period (2^DUTY_WIDTH clock) PWM waveform.
// Emits one duty sample per well-formed period and flags framing violations.
module pwm_duty_decoder #(
    parameter int DUTY_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pwm_in,
    output logic [DUTY_WIDTH-1:0] duty,
    output logic                  duty_valid,
    output logic                  locked,
    output logic                  error
);
    localparam int CW = DUTY_WIDTH + 1;
    localparam logic [CW-1:0] PERIOD = {1'b1, {DUTY_WIDTH{1'b0}}};
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic {IDLE, MEASURE} state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   s_prev_reg;
    logic                   s;
    logic                   rise;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          period_cnt_reg, period_cnt_next;
    logic [CW-1:0]          high_cnt_reg, high_cnt_next;
    logic [CW-1:0]          low_run_reg, low_run_next;
    logic [DUTY_WIDTH-1:0]  duty_reg, duty_next;
    logic                   valid_reg, valid_next;
    logic                   locked_reg, locked_next;
    logic                   error_reg, error_next;
    logic                   period_full;
    logic                   low_full;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = pwm_in;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign s           = sync_reg[SYNC_STAGES-1];
    assign rise        = s & ~s_prev_reg;
    assign period_full = (period_cnt_reg == PERIOD);
    // A low cycle seen now brings the run to a full period.
    assign low_full    = (low_run_reg == PERIOD - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg       <= '0;
            s_prev_reg     <= 1'b0;
            state_reg      <= IDLE;
            period_cnt_reg <= '0;
            high_cnt_reg   <= '0;
            low_run_reg    <= '0;
            duty_reg       <= '0;
            valid_reg      <= 1'b0;
            locked_reg     <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            sync_reg       <= sync_next;
            s_prev_reg     <= s;
            state_reg      <= state_next;
            period_cnt_reg <= period_cnt_next;
            high_cnt_reg   <= high_cnt_next;
            low_run_reg    <= low_run_next;
            duty_reg       <= duty_next;
            valid_reg      <= valid_next;
            locked_reg     <= locked_next;
            error_reg      <= error_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        period_cnt_next = period_cnt_reg;
        high_cnt_next   = high_cnt_reg;
        low_run_next    = low_run_reg;
        case (state_reg)
            IDLE: begin
                if (rise) begin
                    state_next      = MEASURE;
                    period_cnt_next = ONE;
                    high_cnt_next   = ONE;
                end else if (s) begin
                    low_run_next = '0;
                end else if (low_full) begin
                    low_run_next = '0;
                end else begin
                    low_run_next = low_run_reg + ONE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_cnt_next = ONE;
                    high_cnt_next   = ONE;
                end else if (period_full) begin
                    state_next   = IDLE;
                    low_run_next = s ? '0 : ONE;
                end else begin
                    period_cnt_next = period_cnt_reg + ONE;
                    high_cnt_next   = high_cnt_reg + CW'(s);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        duty_next   = duty_reg;
        valid_next  = 1'b0;
        locked_next = locked_reg;
        error_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rise && !s && low_full) begin
                    valid_next  = 1'b1;
                    duty_next   = '0;
                    locked_next = 1'b1;
                end
            end
            MEASURE: begin
                if (rise && period_full) begin
                    valid_next  = 1'b1;
                    // Clamp is unreachable for a well-formed window (it always has a low cycle).
                    duty_next   = high_cnt_reg[DUTY_WIDTH] ? '1 : high_cnt_reg[DUTY_WIDTH-1:0];
                    locked_next = 1'b1;
                end else if (rise || period_full) begin
                    error_next  = 1'b1;
                    locked_next = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign duty       = duty_reg;
    assign duty_valid = valid_reg;
    assign locked     = locked_reg;
    assign error      = error_reg;
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Randomised bench for pwm_duty_decoder (DUTY_WIDTH=4): an event-level reference model
// fills a scoreboard queue and an independent monitor checks every DUT strobe against it.
module tb_pwm_duty_decoder;
    localparam int DW = 4;
    localparam int P  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pwm_in = 1'b0;
    logic [DW-1:0] duty;
    logic          duty_valid;
    logic          locked;
    logic          error;

    pwm_duty_decoder #(.DUTY_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
        .duty(duty), .duty_valid(duty_valid), .locked(locked), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit      is_err;
        int      dval;
        bit      lk;
        int      at;
    } ev_t;

    ev_t exp_q[$];
    int  compared = 0;
    int  mismatched = 0;
    int  edge_no = 0;
    bit  done = 1'b0;
    int  hold_duty = 0;

    // Reference model state: waveform history since the last rising edge.
    bit  m_meas;
    bit  m_prev;
    bit  m_locked;
    int  m_lowcnt;
    int  m_last_rise;
    bit  m_win[$];
    int  gen_cnt = 0;
    int  last_e = 0;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic push_ev(input bit is_err, input int dval, input int e);
        ev_t ev;
        ev.is_err = is_err;
        ev.dval   = dval;
        m_locked  = !is_err;
        ev.lk     = m_locked;
        ev.at     = e + 2;
        exp_q.push_back(ev);
    endtask

    // One synchronised sample v, taken by the DUT's first sync flop at edge e.
    task automatic model_step(input bit v, input int e);
        bit rise;
        int highs;
        rise   = v && !m_prev;
        m_prev = v;
        if (m_meas) begin
            if (rise) begin
                if (e - m_last_rise == P) begin
                    highs = 0;
                    foreach (m_win[i]) highs += int'(m_win[i]);
                    push_ev(1'b0, highs, e);
                end else begin
                    push_ev(1'b1, 0, e);
                end
                m_last_rise = e;
                m_win.delete();
                m_win.push_back(1'b1);
            end else if (e - m_last_rise == P) begin
                push_ev(1'b1, 0, e);
                m_meas   = 1'b0;
                m_lowcnt = v ? 0 : 1;
            end else begin
                m_win.push_back(v);
            end
        end else begin
            if (rise) begin
                m_meas      = 1'b1;
                m_last_rise = e;
                m_win.delete();
                m_win.push_back(1'b1);
            end else if (v) begin
                m_lowcnt = 0;
            end else begin
                m_lowcnt++;
                if (m_lowcnt == P) begin
                    push_ev(1'b0, 0, e);
                    m_lowcnt = 0;
                end
            end
        end
        last_e = e;
    endtask

    task automatic cycle(input bit v);
        @(posedge clk);
        #1;
        pwm_in = v;
        model_step(v, edge_no + 1);
    endtask

    task automatic gen(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            cycle(gen_cnt < d);
            gen_cnt = (gen_cnt + 1) % P;
        end
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_duty", int'(duty), 0);
        check("rst_valid", int'(duty_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_error", int'(error), 0);
        exp_q.delete();
        hold_duty = 0;
        m_meas = 1'b0; m_prev = 1'b0; m_locked = 1'b0; m_lowcnt = 0; m_win.delete();
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Sync flops come out of reset holding zeros that the decoder still consumes.
        model_step(1'b0, edge_no - 1);
        model_step(1'b0, edge_no);
        model_step(pwm_in, edge_no + 1);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && !done) begin
            while (exp_q.size() > 0 && exp_q[0].at < edge_no) begin
                compared++;
                mismatched++;
                $display("FAIL missing_strobe: got none, expected err=%0d duty=%0d at edge %0d",
                         exp_q[0].is_err, exp_q[0].dval, exp_q[0].at);
                void'(exp_q.pop_front());
            end
            if (duty_valid || error) begin
                check("valid_and_error_exclusive", int'(duty_valid && error), 0);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_strobe: got valid=%0d error=%0d duty=%0d, expected none at edge %0d",
                             duty_valid, error, duty, edge_no);
                end else begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    $display("edge %0d: %s duty=%0d locked=%0d", edge_no,
                             duty_valid ? "valid" : "error", duty, locked);
                    check("strobe_edge", edge_no, ev.at);
                    check("strobe_is_error", int'(error), int'(ev.is_err));
                    check("strobe_locked", int'(locked), int'(ev.lk));
                    if (!ev.is_err) begin
                        check("strobe_duty", int'(duty), ev.dval);
                        hold_duty = ev.dval;
                    end
                end
            end else begin
                check("duty_hold", int'(duty), hold_duty);
            end
        end
    end

    initial begin
        do_reset(3);
        gen_cnt = 0;
        // Constant low: duty 0 reported from the idle low run.
        for (int i = 0; i < 40; i++) cycle(1'b0);
        // Free-running duty 5 from a random phase.
        gen_cnt = int'($urandom_range(P - 1));
        gen(5, 6 * P);
        // Duty 15 then a mid-window change to 10.
        gen(15, 3 * P + 7);
        gen(10, 4 * P);
        // Random duties, each held for a few periods.
        for (int k = 0; k < 6; k++) gen(int'($urandom_range(P - 1)), int'($urandom_range(2 * P, 4 * P)));
        // Short periods: rising edges 10 cycles apart.
        for (int k = 0; k < 4; k++) begin
            repeat (3) cycle(1'b1);
            repeat (7) cycle(1'b0);
        end
        gen_cnt = 0;
        gen(6, 4 * P);
        // Stuck high, then released low.
        repeat (40) cycle(1'b1);
        repeat (40) cycle(1'b0);
        // Reset mid-window (during the low phase) while locked on duty 7.
        gen_cnt = 0;
        gen(7, 4 * P);
        while (gen_cnt != 10) gen(7, 1);
        do_reset(2);
        gen(7, 4 * P);
        // Unstructured random waveform.
        for (int i = 0; i < 120; i++) cycle(1'($urandom_range(1)));
        repeat (20) cycle(1'b0);
        // Let the monitor reach the last modelled decision, then stop it.
        while (edge_no < last_e + 2) @(posedge clk);
        #2;
        done = 1'b1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
